countclock_set_ctrl: RTL and testbench

//  Controller for the 12-hour BCD timekeeping counter (hh/mm/ss/pm).
//  - Generates the 1 Hz ena strobe from clk.
//  - Runs the user time-set sequence driven by two debounced buttons.
//  - Commits the edited time to the counter through a one-cycle parallel-load strobe.
//  - Sits between the button debouncers and the loadable counter; the counter's current value feeds back in.

---
 rtl/countclock_set_ctrl_if.sv | 51 +++++
 rtl/countclock_set_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_countclock_set_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/countclock_set_ctrl_if.sv
// Bundles the controller's button, counter-feedback and counter-load signals.
// Combinational only: no latency of its own.
// No backpressure: buttons are single-cycle pulses and load/ena are strobes.
// Optional alarm signals exist only when COUNTCLOCK_ALARM_EN is defined.
interface countclock_set_ctrl_if;
    // Debounced button pulses
    logic       btn_mode;
    logic       btn_inc;
    // Current counter value fed back from the timekeeping counter
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       cur_pm;
    // Strobes and load value towards the counter, plus display hints
    logic       ena;
    logic       load;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic       ld_pm;
    logic [1:0] set_mode;
    logic       blink;
`ifdef COUNTCLOCK_ALARM_EN
    // Alarm time and the one-cycle alarm pulse
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       al_pm;
    logic       alarm;
`endif

    // Controller side: consumes buttons and counter value, drives strobes.
    modport master (
`ifdef COUNTCLOCK_ALARM_EN
        input  al_hh, al_mm, al_pm,
        output alarm,
`endif
        input  btn_mode, btn_inc,
        input  cur_hh, cur_mm, cur_ss, cur_pm,
        output ena, load, ld_hh, ld_mm, ld_pm, set_mode, blink
    );

    // Environment side: debouncers and counter.
    modport slave (
`ifdef COUNTCLOCK_ALARM_EN
        output al_hh, al_mm, al_pm,
        input  alarm,
`endif
        output btn_mode, btn_inc,
        output cur_hh, cur_mm, cur_ss, cur_pm,
        input  ena, load, ld_hh, ld_mm, ld_pm, set_mode, blink
    );
endinterface

// File: rtl/countclock_set_ctrl.sv
// 12-hour BCD clock controller: 1 Hz ena prescaler, two-button time-set FSM, parallel-load commit.
// Latency: every output is registered, reacting one clk after the causing input or state.
// No backpressure: button pulses are consumed on the cycle they arrive; load/ena are fire-and-forget.
// Optional alarm compare is built only when COUNTCLOCK_ALARM_EN is defined.
module countclock_set_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    countclock_set_ctrl_if.master bus
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // set_mode is the state encoding itself, so it is registered for free.
    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_SET_HH = 2'b01,
        S_SET_MM = 2'b10,
        S_COMMIT = 2'b11
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] presc, presc_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic          ena_q, ena_d;
    logic          load_q, load_d;
    logic          blink_q, blink_d;
    logic [7:0]    ld_hh_q, ld_hh_d;
    logic [7:0]    ld_mm_q, ld_mm_d;
    logic          ld_pm_q, ld_pm_d;

    // Hours step 01..09,10,11,12 then back to 01; only legal BCD is produced.
    function automatic logic [7:0] bcd_inc_hh(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h12)
            r = 8'h01;
        else if (v[3:0] == 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    // Minutes step 00..59 then back to 00, no carry out.
    function automatic logic [7:0] bcd_inc_mm(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59)
            r = 8'h00;
        else if (v[3:0] == 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    // State and output registers; reset discards any edit in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RUN;
            presc   <= '0;
            bcnt    <= '0;
            ena_q   <= 1'b0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            ld_hh_q <= 8'h12;
            ld_mm_q <= 8'h00;
            ld_pm_q <= 1'b0;
        end else begin
            state   <= state_d;
            presc   <= presc_d;
            bcnt    <= bcnt_d;
            ena_q   <= ena_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            ld_hh_q <= ld_hh_d;
            ld_mm_q <= ld_mm_d;
            ld_pm_q <= ld_pm_d;
        end
    end

    // Next state and edit datapath; mode wins over a simultaneous inc.
    always_comb begin
        state_d = state;
        ld_hh_d = ld_hh_q;
        ld_mm_d = ld_mm_q;
        ld_pm_d = ld_pm_q;
        case (state)
            S_RUN: begin
                if (bus.btn_mode) begin
                    state_d = S_SET_HH;
                    // Start editing from the time currently shown.
                    ld_hh_d = bus.cur_hh;
                    ld_mm_d = bus.cur_mm;
                    ld_pm_d = bus.cur_pm;
                end
            end
            S_SET_HH: begin
                if (bus.btn_mode) begin
                    state_d = S_SET_MM;
                end else if (bus.btn_inc) begin
                    ld_hh_d = bcd_inc_hh(ld_hh_q);
                    // AM/PM flips when passing 11 -> 12, not at 12 -> 01.
                    if (ld_hh_q == 8'h11)
                        ld_pm_d = ~ld_pm_q;
                end
            end
            S_SET_MM: begin
                if (bus.btn_mode)
                    state_d = S_COMMIT;
                else if (bus.btn_inc)
                    ld_mm_d = bcd_inc_mm(ld_mm_q);
            end
            S_COMMIT: begin
                // Single cycle; buttons deliberately ignored here.
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        load_d = (state_d == S_COMMIT);
    end

    // Prescaler only runs while RUN is held across the edge, so the first ena
    // lands TICK_DIV cycles after reset or after the commit cycle.
    always_comb begin
        presc_d = '0;
        ena_d   = 1'b0;
        if (state == S_RUN && state_d == S_RUN) begin
            if (presc == TICK_MAX) begin
                presc_d = '0;
                ena_d   = 1'b1;
            end else begin
                presc_d = presc + TW'(1);
            end
        end
    end

    // Blink restarts high on entry to each edit field and is low otherwise.
    always_comb begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (state_d == S_SET_HH || state_d == S_SET_MM) begin
            if (state_d != state) begin
                bcnt_d  = '0;
                blink_d = 1'b1;
            end else if (bcnt == BLINK_MAX) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt + BW'(1);
                blink_d = blink_q;
            end
        end
    end

    assign bus.ena      = ena_q;
    assign bus.load     = load_q;
    assign bus.ld_hh    = ld_hh_q;
    assign bus.ld_mm    = ld_mm_q;
    assign bus.ld_pm    = ld_pm_q;
    assign bus.set_mode = state;
    assign bus.blink    = blink_q;

`ifdef COUNTCLOCK_ALARM_EN
    logic match;
    logic match_q;
    logic alarm_q;

    assign match = (bus.cur_hh == bus.al_hh) && (bus.cur_mm == bus.al_mm) &&
                   (bus.cur_pm == bus.al_pm) && (bus.cur_ss == 8'h00);

    // Rising edge of the match in RUN only; history clears while editing so it re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            alarm_q <= 1'b0;
        end else if (state == S_RUN) begin
            match_q <= match;
            alarm_q <= match & ~match_q;
        end else begin
            match_q <= 1'b0;
            alarm_q <= 1'b0;
        end
    end

    assign bus.alarm = alarm_q;
`else
    // Seconds only matter to the alarm compare, which is absent in this build.
    logic unused_ss;
    assign unused_ss = ^bus.cur_ss;
`endif

endmodule

// File: tb/tb_countclock_set_ctrl.sv
// Directed bench for countclock_set_ctrl with a scoreboard of expected outputs.
// Each step queues its expectation, drives one clock, then pops and compares.
// Alarm steps are included only when COUNTCLOCK_ALARM_EN is defined.
module tb_countclock_set_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;

    typedef struct {
        logic [1:0] mode;
        logic       load;
        logic       ena;
        logic       blink;
        logic [7:0] hh;
        logic [7:0] mm;
        logic       pm;
        logic       alarm;
        bit         chk_ena;
        bit         chk_blink;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    countclock_set_ctrl_if bus ();

    countclock_set_ctrl #(
        .TICK_DIV (TICK_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] mode, input logic load,
                                input logic [7:0] hh, input logic [7:0] mm, input logic pm,
                                input logic ena, input logic blink,
                                input bit ce = 1'b1, input bit cb = 1'b1);
        exp_t e;
        e.mode = mode; e.load = load; e.hh = hh; e.mm = mm; e.pm = pm;
        e.ena = ena; e.blink = blink; e.alarm = 1'b0;
        e.chk_ena = ce; e.chk_blink = cb;
        return e;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp({t, ".mode"},  {6'b0, bus.set_mode}, {6'b0, e.mode});
            cmp({t, ".load"},  {7'b0, bus.load},     {7'b0, e.load});
            cmp({t, ".ld_hh"}, bus.ld_hh,            e.hh);
            cmp({t, ".ld_mm"}, bus.ld_mm,            e.mm);
            cmp({t, ".ld_pm"}, {7'b0, bus.ld_pm},    {7'b0, e.pm});
            if (e.chk_ena)
                cmp({t, ".ena"}, {7'b0, bus.ena}, {7'b0, e.ena});
            if (e.chk_blink)
                cmp({t, ".blink"}, {7'b0, bus.blink}, {7'b0, e.blink});
`ifdef COUNTCLOCK_ALARM_EN
            cmp({t, ".alarm"}, {7'b0, bus.alarm}, {7'b0, e.alarm});
`endif
        end
    endtask

    // One clock: queue the expectation, drive buttons, sample 1 ns after the edge.
    task automatic step(input string tag, input logic m, input logic i, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check_out();
    endtask

    task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss, input logic pm);
        bus.cur_hh = hh; bus.cur_mm = mm; bus.cur_ss = ss; bus.cur_pm = pm;
    endtask

    initial begin
        exp_t e;
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(8'h12, 8'h00, 8'h30, 1'b0);
`ifdef COUNTCLOCK_ALARM_EN
        bus.al_hh = 8'h07;
        bus.al_mm = 8'h30;
        bus.al_pm = 1'b0;
`endif

        // Reset values
        step("reset", 1'b0, 1'b0, mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;

        // ena every TICK_DIV cycles from reset release
        for (int k = 1; k <= 20; k++)
            step($sformatf("run_ena%0d", k), 1'b0, 1'b0,
                 mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, logic'(k % TICK_DIV == 0), 1'b0));

        // Enter SET_HH from 11:59 AM, step hours across 11->12->01
        set_cur(8'h11, 8'h59, 8'h30, 1'b0);
        step("hh_enter", 1'b1, 1'b0, mk(2'b01, 1'b0, 8'h11, 8'h59, 1'b0, 1'b0, 1'b1));
        step("hh_11_12", 1'b0, 1'b1, mk(2'b01, 1'b0, 8'h12, 8'h59, 1'b1, 1'b0, 1'b1));
        step("hh_12_01", 1'b0, 1'b1, mk(2'b01, 1'b0, 8'h01, 8'h59, 1'b1, 1'b0, 1'b1));
        // Mode and inc together: mode wins, hours untouched, blink restarts
        step("both_btn", 1'b1, 1'b1, mk(2'b10, 1'b0, 8'h01, 8'h59, 1'b1, 1'b0, 1'b1));
        // Minutes wrap 59->00 without carry into hours
        step("mm_59_00", 1'b0, 1'b1, mk(2'b10, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1));
        step("blink_a",  1'b0, 1'b0, mk(2'b10, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1));
        step("blink_b",  1'b0, 1'b0, mk(2'b10, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int j = 1; j <= 10; j++)
            step($sformatf("mm_inc%0d", j), 1'b0, 1'b1,
                 mk(2'b10, 1'b0, 8'h01, to_bcd(j), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));

        // Commit: one cycle with load, buttons ignored, then RUN with held ld_*
        step("commit", 1'b1, 1'b0, mk(2'b11, 1'b1, 8'h01, 8'h10, 1'b1, 1'b0, 1'b0));
        set_cur(8'h05, 8'h05, 8'h05, 1'b0);
        step("commit_ign", 1'b1, 1'b1, mk(2'b00, 1'b0, 8'h01, 8'h10, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k <= TICK_DIV; k++)
            step($sformatf("post_commit_ena%0d", k), 1'b0, 1'b0,
                 mk(2'b00, 1'b0, 8'h01, 8'h10, 1'b1, logic'(k == TICK_DIV), 1'b0));

        // Second edit: 08->09->10 keeps PM, then reset mid SET_MM discards it
        set_cur(8'h08, 8'h15, 8'h30, 1'b1);
        step("hh2_enter", 1'b1, 1'b0, mk(2'b01, 1'b0, 8'h08, 8'h15, 1'b1, 1'b0, 1'b1));
        step("hh_08_09",  1'b0, 1'b1, mk(2'b01, 1'b0, 8'h09, 8'h15, 1'b1, 1'b0, 1'b1));
        step("hh_09_10",  1'b0, 1'b1, mk(2'b01, 1'b0, 8'h10, 8'h15, 1'b1, 1'b0, 1'b1));
        step("mm2_enter", 1'b1, 1'b0, mk(2'b10, 1'b0, 8'h10, 8'h15, 1'b1, 1'b0, 1'b1));
        step("mm_15_16",  1'b0, 1'b1, mk(2'b10, 1'b0, 8'h10, 8'h16, 1'b1, 1'b0, 1'b1));
        reset = 1'b1;
        step("reset_edit", 1'b0, 1'b0, mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        for (int k = 1; k <= TICK_DIV; k++)
            step($sformatf("post_reset_ena%0d", k), 1'b0, 1'b0,
                 mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, logic'(k == TICK_DIV), 1'b0));

`ifdef COUNTCLOCK_ALARM_EN
        // Alarm fires once on the rising edge of the time match
        set_cur(8'h07, 8'h29, 8'h59, 1'b0);
        step("al_before", 1'b0, 1'b0,
             mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        set_cur(8'h07, 8'h30, 8'h00, 1'b0);
        e = mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e.alarm = 1'b1;
        step("al_fire", 1'b0, 1'b0, e);
        for (int k = 1; k <= 3; k++)
            step($sformatf("al_once%0d", k), 1'b0, 1'b0,
                 mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        e = mk(2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle_tail", 1'b0, 1'b0, e);
`endif

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard leftover observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
